// File: rtl/tinyalu_core.sv
`default_nettype none
// ============================================================================
// Module   : tinyalu_core
// Brief    : TinyALU start/done responder: add/and/xor in one cycle,
//            unsigned 8x8 multiply through a MUL_LATENCY-deep pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tinyalu_core #(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result,
    output logic        illegal_op
);

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;

    logic [15:0]            mul_prod_q [MUL_LATENCY];
    logic [15:0]            mul_prod_d [MUL_LATENCY];
    logic [MUL_LATENCY-1:0] mul_vld_q, mul_vld_d;

    logic [15:0] alu_res;
    logic [15:0] mul_in;

    // Product of the operands presented at acceptance feeds pipeline stage 0.
    assign mul_in = {8'h00, A} * {8'h00, B};

    always_comb begin
        alu_res = 16'h0000;
        case (op_q)
            OP_ADD:  alu_res = {7'b0, {1'b0, a_q} + {1'b0, b_q}};
            OP_AND:  alu_res = {8'h00, a_q & b_q};
            OP_XOR:  alu_res = {8'h00, a_q ^ b_q};
            default: alu_res = 16'h0000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        mul_prod_d[0] = mul_prod_q[0];
        mul_vld_d     = '0;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            mul_prod_d[i] = mul_prod_q[i-1];
            mul_vld_d[i]  = mul_vld_q[i-1];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_NOP: ;
                        OP_ADD, OP_AND, OP_XOR: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op;
                            state_d = ST_BUSY;
                        end
                        OP_MUL: begin
                            a_d           = A;
                            b_d           = B;
                            op_d          = op;
                            mul_prod_d[0] = mul_in;
                            mul_vld_d[0]  = 1'b1;
                            state_d       = ST_BUSY;
                        end
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = ST_WAIT_LOW;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                if (op_q == OP_MUL) begin
                    if (mul_vld_q[MUL_LATENCY-1]) begin
                        result_d = mul_prod_q[MUL_LATENCY-1];
                        done_d   = 1'b1;
                        state_d  = ST_WAIT_LOW;
                    end
                end else begin
                    result_d = alu_res;
                    done_d   = 1'b1;
                    state_d  = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                // A start still held from the completed command must not re-trigger it.
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            op_q      <= OP_NOP;
            result_q  <= 16'h0000;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            mul_vld_q <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                mul_prod_q[i] <= 16'h0000;
            end
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            mul_vld_q <= mul_vld_d;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                mul_prod_q[i] <= mul_prod_d[i];
            end
        end
    end

    assign done       = done_q;
    assign result     = result_q;
    assign illegal_op = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_tinyalu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_tinyalu_core
// Brief    : Directed, table-driven self-checking bench for tinyalu_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tinyalu_core;

    logic        clk;
    logic        reset;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;
    logic        illegal_op;

    int checks;
    int failures;

    tinyalu_core #(.MUL_LATENCY(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .op         (op),
        .start      (start),
        .done       (done),
        .result     (result),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        logic [15:0] res;
        int          hold;
        bit          zap;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Drives one command, driver style: raise start at a negedge, drop it at the
    // negedge where done is seen (or after 'hold' extra cycles).
    task automatic do_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input int lat, input logic [15:0] exp, input int hold,
                          input bit zap, input string nm);
        int n;
        bit seen;
        @(negedge clk);
        check({nm, "_pre_done"}, {31'b0, done}, 32'd0);
        A = a; B = b; op = o; start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (zap && n == 1) begin
                A = 8'h00;
                B = 8'h00;
            end
            if (done) seen = 1'b1;
        end
        check({nm, "_latency"}, n, lat + 1);
        check({nm, "_result"}, {16'b0, result}, {16'b0, exp});
        check({nm, "_no_illegal"}, {31'b0, illegal_op}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({nm, "_hold_no_done"}, {31'b0, done}, 32'd0);
        end
        start = 1'b0;
    endtask

    initial begin
        int dcount;
        checks   = 0;
        failures = 0;
        reset = 1'b1;
        A = 8'h00; B = 8'h00; op = 3'd0; start = 1'b0;

        vecs[0] = '{3'd1, 8'hFF, 8'h01, 1, 16'h0100, 0, 1'b0};
        vecs[1] = '{3'd2, 8'hF0, 8'h3C, 1, 16'h0030, 3, 1'b0};
        vecs[2] = '{3'd3, 8'hF0, 8'h3C, 1, 16'h00CC, 3, 1'b0};
        vecs[3] = '{3'd1, 8'h80, 8'h80, 1, 16'h0100, 0, 1'b0};
        vecs[4] = '{3'd4, 8'h12, 8'h34, 3, 16'h03A8, 0, 1'b0};
        vecs[5] = '{3'd3, 8'hAA, 8'h55, 1, 16'h00FF, 0, 1'b0};
        vecs[6] = '{3'd4, 8'h00, 8'h7F, 3, 16'h0000, 0, 1'b0};
        vecs[7] = '{3'd4, 8'hFF, 8'hFF, 3, 16'hFE01, 0, 1'b1};

        #1;
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_illegal", {31'b0, illegal_op}, 32'd0);
        check("reset_result", {16'b0, result}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].res,
                   vecs[i].hold, vecs[i].zap, $sformatf("vec%0d", i));
        end

        // no_op held one cycle, then an illegal op on the same start.
        @(negedge clk);
        op = 3'd0; A = 8'h11; B = 8'h22; start = 1'b1;
        @(negedge clk);
        check("nop_no_done", {31'b0, done}, 32'd0);
        check("nop_no_illegal", {31'b0, illegal_op}, 32'd0);
        op = 3'd5;
        @(negedge clk);
        check("ill_pulse", {31'b0, illegal_op}, 32'd1);
        check("ill_no_done", {31'b0, done}, 32'd0);
        check("ill_result_kept", {16'b0, result}, 32'h0000FE01);
        @(negedge clk);
        check("ill_pulse_end", {31'b0, illegal_op}, 32'd0);
        start = 1'b0;
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || illegal_op) dcount++;
        end
        check("ill_quiet_after", dcount, 0);

        // Reset one cycle after a mul is accepted.
        A = 8'h10; B = 8'h10; op = 3'd4; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_rst_result", {16'b0, result}, 32'h0);
        check("async_rst_done", {31'b0, done}, 32'd0);
        check("async_rst_illegal", {31'b0, illegal_op}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("no_done_after_rst", dcount, 0);
        do_cmd(3'd1, 8'h02, 8'h03, 1, 16'h0005, 0, 1'b0, "post_rst_add");

        @(negedge clk);
        check("final_done_low", {31'b0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tinyalu_core.md
Name: tinyalu_core

Overview:
- Synthesizable TinyALU responder: the DUT end of the start/done operation protocol that the TinyALU BFM drives and monitors.
- Accepts one command per start assertion and computes on two 8-bit operands.
- Single-cycle path handles add/and/xor; the multiply path is a multi-cycle pipeline.
- Returns a 16-bit result with a one-cycle done pulse.
- Sits under the testbench top, wired directly to the BFM signals A, B, op, start, done, result.

Parameters:
- MUL_LATENCY, 3, clocks from command acceptance to done for mul_op; legal range 2..8.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- A  input  8  operand A, unsigned.
- B  input  8  operand B, unsigned.
- op  input  3  000 no_op, 001 add_op, 010 and_op, 011 xor_op, 100 mul_op, 101..111 illegal.
- start  input  1  command request; held high by the initiator until done is seen.
- done  output  1  one-cycle pulse: result valid for the completed command.
- result  output  16  registered result; holds its value until the next done.
- illegal_op  output  1  one-cycle pulse when a command with op 101..111 is sampled.

Behaviour:
- Reset (async, any time, including mid-command):
  - done=0, illegal_op=0, result=16'h0000.
  - State=IDLE; mul pipeline flushed; latched operands cleared.
  - First command is accepted at the first posedge with reset low.
- States: IDLE, BUSY, WAIT_LOW.
- IDLE:
  - Accept at posedge k when start=1.
  - Latch A, B, op at k; later changes on A/B/op are ignored until the next acceptance.
  - op=no_op: no done, stay IDLE. A start held high with no_op produces nothing.
  - op in 101..111: illegal_op=1 for the cycle after k, no done, go to WAIT_LOW.
  - op in add/and/xor/mul: go to BUSY with latency L. L=1 for add/and/xor; L=MUL_LATENCY for mul.
- BUSY:
  - At posedge k+L, register the result, set done=1, go to WAIT_LOW.
  - done clears at posedge k+L+1.
- WAIT_LOW:
  - Stay while start=1; go to IDLE at the first posedge sampling start=0.
  - A start held high after done never re-triggers the command.
  - Transition WAIT_LOW->IDLE takes one posedge; acceptance of a new command is possible at the following posedge. This meets the initiator's drop-at-negedge / re-raise-at-next-negedge pattern.
- Arithmetic (all unsigned):
  - add: {7'b0, A+B (9-bit carry)}.
  - and: {8'b0, A&B}.
  - xor: {8'b0, A^B}.
  - mul: full 16-bit A*B, no truncation.
- Mul pipeline: MUL_LATENCY-deep register chain carrying the product and a valid bit. Only one command is in flight at a time; the pipeline exists for timing, not throughput.
- Start dropped while BUSY: the command still completes and done still pulses. WAIT_LOW then exits on the next posedge.
- result changes only on a done cycle or on reset; illegal and no_op commands leave it unchanged.
- done and illegal_op are never high in the same cycle.

Test Plan:
- Reset then add: A=8'hFF, B=8'h01, op=001, start held to done → done pulses exactly 1 cycle, at the posedge after acceptance; result=16'h0100.
- Logic ops: and A=8'hF0, B=8'h3C → result=16'h0030; xor with the same operands → result=16'h00CC. Each done is one cycle; start kept high 3 extra cycles yields no second done.
- Mul, MUL_LATENCY=3: A=8'hFF, B=8'hFF → done exactly 3 posedges after acceptance, result=16'hFE01. Changing A/B to 0 during BUSY does not alter the result.
- no_op with start high 1 cycle, then op=101 → no done for no_op. illegal_op pulses once for 101; result keeps its prior value 16'hFE01.
- Assert reset 1 cycle after accepting mul A=8'h10, B=8'h10 → done, result, illegal_op go 0 immediately with no clock edge. No done appears later. A following add 8'h02+8'h03 returns 16'h0005.
- Back-to-back, driver-style (start dropped at the negedge after done, re-raised at the next negedge): add, mul, xor sequence → three done pulses with correct results. No command is lost or duplicated.
